addsub_accum: RTL and testbench

ADDSUB_ACCUM -- requirements
Module: addsub_accum

---
 rtl/addsub_accum.sv | 113 +++++++++++
 tb/tb_addsub_accum.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accum.sv
// addsub_accum: add / subtract / accumulate / load unit with a one-deep
// registered result stage and valid/ready handshakes on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operation request handshake (a, b, mode)
//   out_valid/out_ready  : result handshake (d, cout, ovf)
//   acc                  : running accumulator (modes 2/3 only)
//   op_count             : accepted operations, wraps modulo 2^CNT_W
// Latency 1 cycle; in_ready drops while a result is stalled by out_ready=0.
module addsub_accum #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  mode_e            op;
  logic             accept;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   sum_acc;
  logic [WIDTH-1:0] res_d;
  logic             res_cout;
  logic             res_ovf;
  logic             acc_we;

  assign op       = mode_e'(mode);
  // The output register frees up either when empty or when it is being
  // drained this very cycle, which gives bubble-free back-to-back issue.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_acc = {1'b0, acc} + {1'b0, a};

  always_comb begin
    res_d    = a;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    acc_we   = 1'b0;
    case (op)
      MODE_ADD: begin
        res_d    = sum_ab[MSB:0];
        res_cout = sum_ab[WIDTH];
        res_ovf  = (a[MSB] == b[MSB]) && (sum_ab[MSB] != a[MSB]);
      end
      MODE_SUB: begin
        res_d    = diff_ab[MSB:0];
        // The extra top bit is the borrow; cout reports its complement.
        res_cout = !diff_ab[WIDTH];
        res_ovf  = (a[MSB] != b[MSB]) && (diff_ab[MSB] != a[MSB]);
      end
      MODE_ACC: begin
        res_d    = sum_acc[MSB:0];
        res_cout = sum_acc[WIDTH];
        res_ovf  = (a[MSB] == acc[MSB]) && (sum_acc[MSB] != a[MSB]);
        acc_we   = 1'b1;
      end
      MODE_LOAD: begin
        res_d    = a;
        acc_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      d         <= res_d;
      cout      <= res_cout;
      ovf       <= res_ovf;
      op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (acc_we) begin
        acc <= res_d;
      end
    end else if (out_ready) begin
      // Result drained with nothing new behind it; data fields keep their
      // last value, only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
module tb_addsub_accum;

  localparam int W    = 4;
  localparam int C    = 8;
  localparam int MAXU = 1 << W;

  typedef struct packed {
    logic [W-1:0] d;
    logic         cout;
    logic         ovf;
    logic [W-1:0] acc;
    logic [C-1:0] cnt;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         cout;
  logic         ovf;
  logic [W-1:0] acc;
  logic [C-1:0] op_count;

  exp_t         scb[$];
  logic [W-1:0] acc_m;
  logic [C-1:0] cnt_m;
  int           errors;
  int           checks;

  addsub_accum #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .cout(cout), .ovf(ovf),
    .acc(acc), .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: integer arithmetic with signed range checks for ovf.
  task automatic predict(input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input logic [1:0] pm);
    exp_t e;
    int ua, ub, sa, sbv, r, sr;
    ua  = int'(pa);
    ub  = (pm == 2'd2) ? int'(acc_m) : int'(pb);
    sa  = (ua >= MAXU/2) ? ua - MAXU : ua;
    sbv = (ub >= MAXU/2) ? ub - MAXU : ub;
    e = '0;
    case (pm)
      2'd1: begin
        r = ua - ub; sr = sa - sbv; e.cout = (ua >= ub);
        if (r < 0) r = r + MAXU;
      end
      2'd3: begin
        r = ua; sr = 0; e.cout = 1'b0;
      end
      default: begin
        r = ua + ub; sr = sa + sbv; e.cout = (r >= MAXU);
      end
    endcase
    e.d   = r[W-1:0];
    e.ovf = (pm != 2'd3) && ((sr > MAXU/2 - 1) || (sr < -(MAXU/2)));
    if (pm >= 2'd2) acc_m = e.d;
    cnt_m = cnt_m + 1'b1;
    e.acc = acc_m;
    e.cnt = cnt_m;
    scb.push_back(e);
  endtask

  // One accepted operation with the sink ready; returns 1 ns after the edge.
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic [1:0] dm);
    a = da; b = db; mode = dm; in_valid = 1'b1; out_ready = 1'b1;
    predict(da, db, dm);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0; acc_m = '0; cnt_m = '0;
    #2;
    checks++;
    if ({out_valid, d, cout, ovf, acc, op_count} !== '0)
      $display("FAIL reset_state: got %b required 0",
               {out_valid, d, cout, ovf, acc, op_count});
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0",
               in_ready, out_valid);
    if (in_ready !== 1'b1 || out_valid !== 1'b0) errors++;
  endtask

  task automatic test_add();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    exp_t e;
    va[0] = 4'd0;  vb[0] = 4'd15;
    va[1] = 4'd15; vb[1] = 4'd1;
    va[2] = 4'd7;  vb[2] = 4'd1;
    for (int i = 3; i < 8; i++) begin
      va[i] = W'($urandom_range(0, MAXU-1));
      vb[i] = W'($urandom_range(0, MAXU-1));
    end
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], 2'd0);
      checks++;
      if (scb.size() == 0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL add_valid[%0d]: out_valid=%b queue=%0d", i, out_valid, scb.size());
      end else begin
        e = scb.pop_front();
        if ({d, cout, ovf, acc, op_count} !== e) begin
          errors++;
          $display("FAIL add[%0d] %0d+%0d: got d=%0d c=%b v=%b acc=%0d cnt=%0d required d=%0d c=%b v=%b acc=%0d cnt=%0d",
                   i, va[i], vb[i], d, cout, ovf, acc, op_count, e.d, e.cout, e.ovf, e.acc, e.cnt);
        end
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    exp_t e;
    va[0] = 4'd3; vb[0] = 4'd5;
    va[1] = 4'd8; vb[1] = 4'd1;
    va[2] = 4'd6; vb[2] = 4'd6;
    for (int i = 3; i < 8; i++) begin
      va[i] = W'($urandom_range(0, MAXU-1));
      vb[i] = W'($urandom_range(0, MAXU-1));
    end
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], 2'd1);
      checks++;
      if (scb.size() == 0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sub_valid[%0d]: out_valid=%b queue=%0d", i, out_valid, scb.size());
      end else begin
        e = scb.pop_front();
        if ({d, cout, ovf, acc, op_count} !== e) begin
          errors++;
          $display("FAIL sub[%0d] %0d-%0d: got d=%0d c=%b v=%b acc=%0d cnt=%0d required d=%0d c=%b v=%b acc=%0d cnt=%0d",
                   i, va[i], vb[i], d, cout, ovf, acc, op_count, e.d, e.cout, e.ovf, e.acc, e.cnt);
        end
      end
    end
  endtask

  task automatic test_accum();
    logic [W-1:0] va [11];
    logic [W-1:0] vb [11];
    logic [1:0]   vm [11];
    exp_t e;
    va[0] = 4'd15; vb[0] = 4'd0; vm[0] = 2'd3;
    va[1] = 4'd2;  vb[1] = 4'd3; vm[1] = 2'd0;
    va[2] = 4'd1;  vb[2] = 4'd9; vm[2] = 2'd2;
    for (int i = 3; i < 11; i++) begin
      va[i] = W'($urandom_range(0, MAXU-1));
      vb[i] = W'($urandom_range(0, MAXU-1));
      vm[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 11; i++) begin
      drive(va[i], vb[i], vm[i]);
      checks++;
      if (scb.size() == 0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL accum_valid[%0d]: out_valid=%b queue=%0d", i, out_valid, scb.size());
      end else begin
        e = scb.pop_front();
        if ({d, cout, ovf, acc, op_count} !== e) begin
          errors++;
          $display("FAIL accum[%0d] mode=%0d a=%0d: got d=%0d c=%b v=%b acc=%0d cnt=%0d required d=%0d c=%b v=%b acc=%0d cnt=%0d",
                   i, vm[i], va[i], d, cout, ovf, acc, op_count, e.d, e.cout, e.ovf, e.acc, e.cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [W-1:0] ta, tb_v;
    logic [1:0]   tm;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ta   = W'($urandom_range(0, MAXU-1));
      tb_v = W'($urandom_range(0, MAXU-1));
      tm   = 2'($urandom_range(0, 3));
      a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
      predict(ta, tb_v, tm);
      @(posedge clk); #1;
      checks++;
      if (scb.size() == 0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: out_valid=%b queue=%0d", i, out_valid, scb.size());
      end else begin
        e = scb.pop_front();
        if ({d, cout, ovf, acc, op_count} !== e) begin
          errors++;
          $display("FAIL b2b[%0d]: got d=%0d c=%b v=%b acc=%0d cnt=%0d required d=%0d c=%b v=%b acc=%0d cnt=%0d",
                   i, d, cout, ovf, acc, op_count, e.d, e.cout, e.ovf, e.acc, e.cnt);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || acc !== acc_m || op_count !== cnt_m) begin
      errors++;
      $display("FAIL drain_idle: out_valid=%b acc=%0d cnt=%0d required 0 acc=%0d cnt=%0d",
               out_valid, acc, op_count, acc_m, cnt_m);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    drive(4'd4, 4'd3, 2'd0);
    e = '0;
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL stall_setup: queue empty");
    end else begin
      e = scb.pop_front();
      if ({d, cout, ovf, acc, op_count} !== e) begin
        errors++;
        $display("FAIL stall_setup: got d=%0d cnt=%0d required d=%0d cnt=%0d", d, op_count, e.d, e.cnt);
      end
    end
    out_ready = 1'b0;
    a = 4'd5; b = 4'd2; mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {d, cout, ovf, acc, op_count} !== e) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b d=%0d cnt=%0d required 0/1 d=%0d cnt=%0d",
                 i, in_ready, out_valid, d, op_count, e.d, e.cnt);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b required 1", in_ready);
    end
    predict(4'd5, 4'd2, 2'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL stall_release: queue empty");
    end else begin
      e = scb.pop_front();
      if ({d, cout, ovf, acc, op_count} !== e || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_release: got d=%0d cnt=%0d vld=%b required d=%0d cnt=%0d vld=1",
                 d, op_count, out_valid, e.d, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    drive(4'd1, 4'd0, 2'd3);
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL rst_setup: queue empty");
    end else begin
      e = scb.pop_front();
      if ({d, cout, ovf, acc, op_count} !== e) begin
        errors++;
        $display("FAIL rst_setup: got d=%0d acc=%0d required d=%0d acc=%0d", d, acc, e.d, e.acc);
      end
    end
    out_ready = 1'b0;
    a = 4'd2; b = 4'd2; mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, d, cout, ovf, acc, op_count} !== '0) begin
      errors++;
      $display("FAIL rst_async: got %b required 0", {out_valid, d, cout, ovf, acc, op_count});
    end
    in_valid = 1'b0;
    scb.delete();
    acc_m = '0;
    cnt_m = '0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== '0) begin
      errors++;
      $display("FAIL rst_after: in_ready=%b out_valid=%b cnt=%0d required 1/0/0",
               in_ready, out_valid, op_count);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [W-1:0] ta, tb_v;
    logic [1:0]   tm;
    int bad;
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ta   = W'($urandom_range(0, MAXU-1));
      tb_v = W'($urandom_range(0, MAXU-1));
      tm   = 2'($urandom_range(0, 3));
      a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
      predict(ta, tb_v, tm);
      @(posedge clk); #1;
      checks++;
      if (scb.size() == 0) begin
        errors++;
        $display("FAIL wrap_queue[%0d]: queue empty", i);
      end else begin
        e = scb.pop_front();
        if ({d, cout, ovf, acc, op_count} !== e) begin
          errors++;
          if (bad < 5)
            $display("FAIL wrap[%0d]: got d=%0d c=%b v=%b acc=%0d cnt=%0d required d=%0d c=%b v=%b acc=%0d cnt=%0d",
                     i, d, cout, ovf, acc, op_count, e.d, e.cout, e.ovf, e.acc, e.cnt);
          bad++;
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (op_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_final: op_count=%0d required 0", op_count);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_sub();
    test_accum();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
